// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry type encoding for the reorder buffer.
package reorder_buffer_pkg;

   localparam int ROB_WIDTH_BIT = 3;

   typedef enum logic [1:0] {
      ROB_REG   = 2'd0,
      ROB_BR    = 2'd1,
      ROB_STORE = 2'd2
   } rob_type_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, commit and operand-query signals between the core and the ROB.
interface reorder_buffer_if #(
   parameter int ROB_W = reorder_buffer_pkg::ROB_WIDTH_BIT
);
   import reorder_buffer_pkg::*;

   logic             issue_valid;
   rob_type_e        issue_type;
   logic [4:0]       issue_rd;
   logic             issue_pred_taken;
   logic [31:0]      issue_alt_pc;

   logic             rob_full;
   logic [4:0]       new_reg_id;
   logic [ROB_W-1:0] new_ROB_id;

   logic             cdb_valid;
   logic [ROB_W-1:0] cdb_rob_id;
   logic [31:0]      cdb_val;
   logic             cdb_br_taken;

   logic [4:0]       write_reg_id;
   logic [ROB_W-1:0] write_ROB_id;
   logic [31:0]      write_val;

   logic [ROB_W-1:0] rs1_id;
   logic [ROB_W-1:0] rs2_id;
   logic             rs1_ready;
   logic             rs2_ready;
   logic [31:0]      rs1_val;
   logic [31:0]      rs2_val;

   logic             store_commit;
   logic             clear_flag;
   logic [31:0]      redirect_pc;

   modport master (
      output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
      output cdb_valid, cdb_rob_id, cdb_val, cdb_br_taken,
      output rs1_id, rs2_id,
      input  rob_full, new_reg_id, new_ROB_id,
      input  write_reg_id, write_ROB_id, write_val,
      input  rs1_ready, rs2_ready, rs1_val, rs2_val,
      input  store_commit, clear_flag, redirect_pc
   );

   modport slave (
      input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
      input  cdb_valid, cdb_rob_id, cdb_val, cdb_br_taken,
      input  rs1_id, rs2_id,
      output rob_full, new_reg_id, new_ROB_id,
      output write_reg_id, write_ROB_id, write_val,
      output rs1_ready, rs2_ready, rs1_val, rs2_val,
      output store_commit, clear_flag, redirect_pc
   );

endinterface

// File: rtl/reorder_buffer_fwd.sv
// One operand-query port: stored entry result, overridden by a same-cycle CDB hit.
module reorder_buffer_fwd #(
   parameter int ROB_WIDTH_BIT = 3,
   parameter int DEPTH         = 1 << ROB_WIDTH_BIT
) (
   input  logic [DEPTH-1:0]         i_ready,
   input  logic [31:0]              i_val [DEPTH],
   input  logic                     i_cdb_valid,
   input  logic [ROB_WIDTH_BIT-1:0] i_cdb_rob_id,
   input  logic [31:0]              i_cdb_val,
   input  logic [ROB_WIDTH_BIT-1:0] i_rs_id,
   output logic                     o_rs_ready,
   output logic [31:0]              o_rs_val
);

   logic w_hit;

   assign w_hit      = i_cdb_valid && (i_cdb_rob_id == i_rs_id);
   assign o_rs_ready = w_hit || i_ready[i_rs_id];
   assign o_rs_val   = w_hit ? i_cdb_val : i_val[i_rs_id];

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, complete via CDB, retire from head,
// and flush everything on a mispredicted branch commit.
module reorder_buffer #(
   parameter int ROB_WIDTH_BIT = reorder_buffer_pkg::ROB_WIDTH_BIT
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic rdy_in,
   reorder_buffer_if.slave bus
);
   import reorder_buffer_pkg::*;

   localparam int DEPTH = 1 << ROB_WIDTH_BIT;
   localparam int CNT_W = ROB_WIDTH_BIT + 1;

   typedef logic [ROB_WIDTH_BIT-1:0] idx_t;

   idx_t             r_head;
   idx_t             r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_clear;
   logic [31:0]      r_redirect;

   logic [DEPTH-1:0] w_ready;
   logic [DEPTH-1:0] w_pred;
   logic [DEPTH-1:0] w_br_taken;
   rob_type_e        w_type [DEPTH];
   logic [4:0]       w_rd   [DEPTH];
   logic [31:0]      w_alt  [DEPTH];
   logic [31:0]      w_val  [DEPTH];

   logic w_full, w_issue, w_commit, w_mispredict, w_flush;

   assign w_full       = (r_count == CNT_W'(DEPTH));
   assign w_issue      = rdy_in && bus.issue_valid && !w_full && !r_clear;
   // A non-zero count guarantees the head entry is busy, so its ready bit alone gates retirement.
   assign w_commit     = rdy_in && !r_clear && (r_count != '0) && w_ready[r_head];
   assign w_mispredict = (w_type[r_head] == ROB_BR) && (w_br_taken[r_head] != w_pred[r_head]);
   assign w_flush      = w_commit && w_mispredict;

   assign bus.rob_full     = w_full;
   assign bus.new_ROB_id   = r_tail;
   assign bus.new_reg_id   = (w_issue && bus.issue_type == ROB_REG) ? bus.issue_rd : 5'd0;
   assign bus.write_reg_id = (w_commit && w_type[r_head] == ROB_REG) ? w_rd[r_head] : 5'd0;
   assign bus.write_ROB_id = r_head;
   assign bus.write_val    = w_val[r_head];
   assign bus.store_commit = w_commit && (w_type[r_head] == ROB_STORE);
   assign bus.clear_flag   = r_clear;
   assign bus.redirect_pc  = r_redirect;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_clear    <= 1'b0;
         r_redirect <= '0;
      end else begin
         r_clear <= 1'b0;
         if (w_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_clear    <= 1'b1;
            r_redirect <= w_alt[r_head];
         end else begin
            if (w_issue)  r_tail <= r_tail + idx_t'(1);
            if (w_commit) r_head <= r_head + idx_t'(1);
            case ({w_issue, w_commit})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic      r_busy, r_ready, r_pred, r_br_taken;
      rob_type_e r_type;
      logic [4:0]  r_rd;
      logic [31:0] r_alt, r_val;
      logic w_alloc, w_retire, w_wb;

      assign w_alloc  = w_issue && (r_tail == idx_t'(gi));
      assign w_retire = w_commit && (r_head == idx_t'(gi));
      // Writebacks to idle or just-retiring entries are stale and dropped.
      assign w_wb     = rdy_in && bus.cdb_valid && (bus.cdb_rob_id == idx_t'(gi))
                        && r_busy && !w_retire;

      always_ff @(posedge clk_in or negedge rst_in) begin
         if (!rst_in) begin
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_pred     <= 1'b0;
            r_br_taken <= 1'b0;
            r_type     <= ROB_REG;
            r_rd       <= '0;
            r_alt      <= '0;
            r_val      <= '0;
         end else if (w_flush) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
         end else begin
            if (w_alloc) begin
               r_busy  <= 1'b1;
               r_ready <= 1'b0;
               r_type  <= bus.issue_type;
               r_rd    <= bus.issue_rd;
               r_pred  <= bus.issue_pred_taken;
               r_alt   <= bus.issue_alt_pc;
            end else if (w_retire) begin
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
            if (w_wb) begin
               r_ready    <= 1'b1;
               r_val      <= bus.cdb_val;
               r_br_taken <= bus.cdb_br_taken;
            end
         end
      end

      assign w_ready[gi]    = r_ready;
      assign w_pred[gi]     = r_pred;
      assign w_br_taken[gi] = r_br_taken;
      assign w_type[gi]     = r_type;
      assign w_rd[gi]       = r_rd;
      assign w_alt[gi]      = r_alt;
      assign w_val[gi]      = r_val;
   end

   idx_t        w_rs_id    [2];
   logic        w_rs_ready [2];
   logic [31:0] w_rs_val   [2];

   assign w_rs_id[0]    = bus.rs1_id;
   assign w_rs_id[1]    = bus.rs2_id;
   assign bus.rs1_ready = w_rs_ready[0];
   assign bus.rs2_ready = w_rs_ready[1];
   assign bus.rs1_val   = w_rs_val[0];
   assign bus.rs2_val   = w_rs_val[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_query
      reorder_buffer_fwd #(
         .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
         .DEPTH         (DEPTH)
      ) u_fwd (
         .i_ready      (w_ready),
         .i_val        (w_val),
         .i_cdb_valid  (bus.cdb_valid),
         .i_cdb_rob_id (bus.cdb_rob_id),
         .i_cdb_val    (bus.cdb_val),
         .i_rs_id      (w_rs_id[gi]),
         .o_rs_ready   (w_rs_ready[gi]),
         .o_rs_val     (w_rs_val[gi])
      );
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: commit scoreboard, query vector table, directed corners.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   typedef struct {
      logic [4:0]  rd;
      logic [2:0]  rob;
      logic [31:0] val;
      logic        is_store;
   } sb_t;

   typedef struct {
      logic [2:0]  rs_id;
      logic        cdb_v;
      logic [2:0]  cdb_id;
      logic [31:0] cdb_val;
      logic        exp_ready;
      logic        chk_val;
      logic [31:0] exp_val;
   } qvec_t;

   typedef struct {
      int          id;
      logic [31:0] val;
   } wb_t;

   logic clk, rst_n, rdy;
   int   n_checks = 0;
   int   n_errors = 0;
   sb_t  sb[$];
   wb_t  wbq[$];
   qvec_t vecs[7];

   reorder_buffer_if #(.ROB_W(3)) bus ();

   reorder_buffer dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .rdy_in (rdy),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [2:0] rob, input logic [31:0] val,
                       input logic st);
      sb_t e;
      e.rd = rd; e.rob = rob; e.val = val; e.is_store = st;
      sb.push_back(e);
   endtask

   // Observe commit outputs mid-cycle, then advance one clock and drop one-shot strobes.
   task automatic step();
      sb_t e;
      @(negedge clk);
      if (rst_n && (bus.write_reg_id != 5'd0 || bus.store_commit)) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_commit actual rd=%0d rob=%0d store=%0b required none",
                     bus.write_reg_id, bus.write_ROB_id, bus.store_commit);
         end else begin
            e = sb.pop_front();
            chk("commit_rd", 32'(bus.write_reg_id), 32'(e.rd));
            chk("commit_store", 32'(bus.store_commit), 32'(e.is_store));
            if (!e.is_store) begin
               chk("commit_rob", 32'(bus.write_ROB_id), 32'(e.rob));
               chk("commit_val", bus.write_val, e.val);
            end
            $display("commit rd=%0d rob=%0d val=%h store=%0b", bus.write_reg_id,
                     bus.write_ROB_id, bus.write_val, bus.store_commit);
         end
      end
      @(posedge clk);
      #1;
      bus.issue_valid  = 1'b0;
      bus.cdb_valid    = 1'b0;
      bus.cdb_br_taken = 1'b0;
   endtask

   task automatic issue(input rob_type_e t, input logic [4:0] rd, input logic pred,
                        input logic [31:0] alt);
      bus.issue_valid      = 1'b1;
      bus.issue_type       = t;
      bus.issue_rd         = rd;
      bus.issue_pred_taken = pred;
      bus.issue_alt_pc     = alt;
   endtask

   task automatic cdb(input logic [2:0] id, input logic [31:0] v, input logic brt);
      bus.cdb_valid    = 1'b1;
      bus.cdb_rob_id   = id;
      bus.cdb_val      = v;
      bus.cdb_br_taken = brt;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      sb.delete();
      wbq.delete();
   endtask

   task automatic drain(input int bound);
      int c = 0;
      while (sb.size() > 0 && c < bound) begin
         step();
         c++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain actual=%0d_pending required=0", sb.size());
      end
   endtask

   initial begin
      int m_head, m_tail, m_count, commits, cyc, seq;
      logic m_ready [8];
      logic acc, mc, did_wb;
      logic [4:0] s_rd;
      wb_t w;

      rst_n = 1'b0;
      rdy   = 1'b1;
      bus.issue_valid = 1'b0; bus.issue_type = ROB_REG; bus.issue_rd = '0;
      bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = '0;
      bus.cdb_valid = 1'b0; bus.cdb_rob_id = '0; bus.cdb_val = '0; bus.cdb_br_taken = 1'b0;
      bus.rs1_id = '0; bus.rs2_id = '0;

      // Reset state
      #12;
      chk("rst_full", 32'(bus.rob_full), 0);
      chk("rst_tail", 32'(bus.new_ROB_id), 0);
      chk("rst_clear", 32'(bus.clear_flag), 0);
      chk("rst_redirect", bus.redirect_pc, 0);
      chk("rst_write_reg", 32'(bus.write_reg_id), 0);
      chk("rst_store", 32'(bus.store_commit), 0);
      chk("rst_rs1_ready", 32'(bus.rs1_ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Minimum latency: issue t, writeback t+1, commit t+2
      issue(ROB_REG, 5'd5, 1'b0, 32'h0);
      #1;
      chk("new_reg_id", 32'(bus.new_reg_id), 5);
      push(5'd5, 3'd0, 32'h1234, 1'b0);
      step();
      cdb(3'd0, 32'h1234, 1'b0);
      chk("no_early_commit", 32'(bus.write_reg_id), 0);
      step();
      chk("lat_write_reg", 32'(bus.write_reg_id), 5);
      chk("lat_write_rob", 32'(bus.write_ROB_id), 0);
      chk("lat_write_val", bus.write_val, 32'h1234);
      step();

      // Store commit held by rdy_in, then a single-cycle pulse
      issue(ROB_STORE, 5'd7, 1'b0, 32'h0);
      #1;
      chk("new_reg_store", 32'(bus.new_reg_id), 0);
      push(5'd0, 3'd1, 32'h0, 1'b1);
      step();
      cdb(3'd1, 32'h0, 1'b0);
      step();
      rdy = 1'b0;
      #1;
      chk("store_held", 32'(bus.store_commit), 0);
      step();
      step();
      rdy = 1'b1;
      #1;
      chk("store_pulse_on", 32'(bus.store_commit), 1);
      step();
      chk("store_pulse_off", 32'(bus.store_commit), 0);

      // Correctly predicted branch retires without a flush
      issue(ROB_BR, 5'd0, 1'b1, 32'h200);
      step();
      issue(ROB_REG, 5'd7, 1'b0, 32'h0);
      push(5'd7, 3'd3, 32'h77, 1'b0);
      step();
      cdb(3'd2, 32'h0, 1'b1);
      step();
      cdb(3'd3, 32'h77, 1'b0);
      repeat (3) begin
         chk("no_clear_good_br", 32'(bus.clear_flag), 0);
         step();
      end
      drain(10);

      // Operand query / same-cycle forward table
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(ROB_REG, 5'(i + 1), 1'b0, 32'h0);
         step();
      end
      push(5'd1, 3'd0, 32'h1000, 1'b0);
      push(5'd2, 3'd1, 32'hAAAA, 1'b0);
      push(5'd3, 3'd2, 32'h2222, 1'b0);
      push(5'd4, 3'd3, 32'h3333, 1'b0);
      cdb(3'd1, 32'hAAAA, 1'b0);
      step();
      cdb(3'd2, 32'h2222, 1'b0);
      step();
      vecs[0] = '{3'd1, 1'b0, 3'd0, 32'h0,    1'b1, 1'b1, 32'hAAAA};
      vecs[1] = '{3'd2, 1'b0, 3'd0, 32'h0,    1'b1, 1'b1, 32'h2222};
      vecs[2] = '{3'd3, 1'b0, 3'd0, 32'h0,    1'b0, 1'b0, 32'h0};
      vecs[3] = '{3'd3, 1'b1, 3'd3, 32'hBEEF, 1'b1, 1'b1, 32'hBEEF};
      vecs[4] = '{3'd0, 1'b1, 3'd3, 32'hBEEF, 1'b0, 1'b0, 32'h0};
      vecs[5] = '{3'd1, 1'b1, 3'd1, 32'h5555, 1'b1, 1'b1, 32'h5555};
      vecs[6] = '{3'd0, 1'b1, 3'd0, 32'h1000, 1'b1, 1'b1, 32'h1000};
      for (int i = 0; i < 7; i++) begin
         bus.rs1_id     = vecs[i].rs_id;
         bus.rs2_id     = vecs[i].rs_id;
         bus.cdb_valid  = vecs[i].cdb_v;
         bus.cdb_rob_id = vecs[i].cdb_id;
         bus.cdb_val    = vecs[i].cdb_val;
         #1;
         $display("query id=%0d cdb=%0b ready=%0b val=%h", vecs[i].rs_id, vecs[i].cdb_v,
                  bus.rs1_ready, bus.rs1_val);
         chk("rs1_ready", 32'(bus.rs1_ready), 32'(vecs[i].exp_ready));
         chk("rs2_ready", 32'(bus.rs2_ready), 32'(vecs[i].exp_ready));
         if (vecs[i].chk_val) begin
            chk("rs1_val", bus.rs1_val, vecs[i].exp_val);
            chk("rs2_val", bus.rs2_val, vecs[i].exp_val);
         end
      end
      bus.cdb_valid = 1'b0;
      @(posedge clk);
      #1;
      cdb(3'd0, 32'h1000, 1'b0);
      step();
      cdb(3'd3, 32'h3333, 1'b0);
      step();
      drain(10);

      // Fill to full, refuse the 9th, then out-of-order writeback retires in order
      do_reset();
      for (int i = 0; i < 8; i++) begin
         issue(ROB_REG, 5'(i + 1), 1'b0, 32'h0);
         push(5'(i + 1), 3'(i), 32'hF00 + 32'(i), 1'b0);
         step();
      end
      chk("full_after_8", 32'(bus.rob_full), 1);
      issue(ROB_REG, 5'd20, 1'b0, 32'h0);
      #1;
      chk("refuse_full_newreg", 32'(bus.new_reg_id), 0);
      step();
      chk("full_after_9th", 32'(bus.rob_full), 1);
      chk("tail_after_9th", 32'(bus.new_ROB_id), 0);
      cdb(3'd2, 32'hF02, 1'b0);
      step();
      cdb(3'd1, 32'hF01, 1'b0);
      step();
      cdb(3'd0, 32'hF00, 1'b0);
      step();
      issue(ROB_REG, 5'd21, 1'b0, 32'h0);
      #1;
      chk("refuse_full_commit", 32'(bus.new_reg_id), 0);
      chk("order0_rob", 32'(bus.write_ROB_id), 0);
      chk("order0_reg", 32'(bus.write_reg_id), 1);
      step();
      chk("order1_rob", 32'(bus.write_ROB_id), 1);
      chk("order1_reg", 32'(bus.write_reg_id), 2);
      step();
      chk("order2_rob", 32'(bus.write_ROB_id), 2);
      chk("order2_reg", 32'(bus.write_reg_id), 3);
      step();
      chk("order_gap", 32'(bus.write_reg_id), 0);
      for (int i = 3; i < 8; i++) begin
         cdb(3'(i), 32'hF00 + 32'(i), 1'b0);
         step();
      end
      drain(20);

      // Mispredicted branch flushes three younger ready entries
      do_reset();
      issue(ROB_BR, 5'd0, 1'b0, 32'h100);
      step();
      repeat (3) begin
         issue(ROB_REG, 5'd9, 1'b0, 32'h0);
         step();
      end
      for (int i = 1; i < 4; i++) begin
         cdb(3'(i), 32'hDEAD, 1'b0);
         step();
      end
      cdb(3'd0, 32'h0, 1'b1);
      step();
      chk("clear_before", 32'(bus.clear_flag), 0);
      step();
      issue(ROB_REG, 5'd3, 1'b0, 32'h0);
      #1;
      chk("clear_flag", 32'(bus.clear_flag), 1);
      chk("redirect_pc", bus.redirect_pc, 32'h100);
      chk("clear_tail", 32'(bus.new_ROB_id), 0);
      chk("clear_full", 32'(bus.rob_full), 0);
      chk("clear_refuse_issue", 32'(bus.new_reg_id), 0);
      step();
      chk("clear_one_cycle", 32'(bus.clear_flag), 0);
      repeat (4) step();
      for (int i = 0; i < 7; i++) begin
         issue(ROB_REG, 5'(i + 10), 1'b0, 32'h0);
         push(5'(i + 10), 3'(i), 32'hB0 + 32'(i), 1'b0);
         step();
      end
      chk("flush_count_7", 32'(bus.rob_full), 0);
      chk("flush_tail_7", 32'(bus.new_ROB_id), 7);
      issue(ROB_REG, 5'd17, 1'b0, 32'h0);
      push(5'd17, 3'd7, 32'hB7, 1'b0);
      step();
      chk("flush_count_8", 32'(bus.rob_full), 1);
      for (int i = 0; i < 8; i++) begin
         cdb(3'(i), 32'hB0 + 32'(i), 1'b0);
         step();
      end
      drain(20);

      // Reset mid-operation discards a pending commit
      do_reset();
      issue(ROB_REG, 5'd1, 1'b0, 32'h0);
      step();
      issue(ROB_REG, 5'd2, 1'b0, 32'h0);
      step();
      cdb(3'd1, 32'h11, 1'b0);
      step();
      cdb(3'd0, 32'h10, 1'b0);
      step();
      chk("pre_rst_commit", 32'(bus.write_reg_id), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_write_reg", 32'(bus.write_reg_id), 0);
      chk("rst_mid_tail", 32'(bus.new_ROB_id), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_mid_full", 32'(bus.rob_full), 0);
      repeat (4) step();

      // Sustained issue/commit across the wrap against a pointer model
      do_reset();
      m_head = 0; m_tail = 0; m_count = 0; commits = 0; cyc = 0; seq = 0;
      for (int i = 0; i < 8; i++) m_ready[i] = 1'b0;
      while (commits < 20 && cyc < 200) begin
         chk("model_full", 32'(bus.rob_full), 32'(m_count == 8));
         chk("model_tail", 32'(bus.new_ROB_id), 32'(m_tail));
         s_rd = 5'((seq % 31) + 1);
         issue(ROB_REG, s_rd, 1'b0, 32'h0);
         acc    = (m_count < 8);
         mc     = (m_count > 0) && m_ready[m_head];
         did_wb = 1'b0;
         if (cyc >= 8 && (cyc % 4) != 0 && wbq.size() > 0) begin
            w = wbq.pop_front();
            cdb(3'(w.id), w.val, 1'b0);
            did_wb = 1'b1;
         end
         if (acc) begin
            push(s_rd, 3'(m_tail), 32'hC000_0000 + 32'(seq), 1'b0);
            wbq.push_back('{m_tail, 32'hC000_0000 + 32'(seq)});
            seq++;
         end
         #1;
         chk("model_new_reg", 32'(bus.new_reg_id), acc ? 32'(s_rd) : 32'd0);
         step();
         if (mc) begin
            m_ready[m_head] = 1'b0;
            m_head = (m_head + 1) % 8;
            commits++;
         end
         if (acc) begin
            m_ready[m_tail] = 1'b0;
            m_tail = (m_tail + 1) % 8;
         end
         if (did_wb) m_ready[w.id] = 1'b1;
         m_count = m_count + int'(acc) - int'(mc);
         cyc++;
      end
      while (wbq.size() > 0) begin
         w = wbq.pop_front();
         cdb(3'(w.id), w.val, 1'b0);
         step();
      end
      drain(20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
